// File: rtl/bfly_stage_sequencer.sv
// bfly_stage_sequencer: control block for one radix-2 DIF butterfly stage.
// The first half-frame of 16-lane input blocks goes into a half-frame
// delay buffer. Each block of the second half-frame is paired with its
// buffered partner to fire the butterfly. The block also steps both
// twiddle ROM addresses.
// Optional build macro STAGE_SEQ_FRMCNT_EN adds the frame_cnt and stall_cnt
// status outputs.
module bfly_stage_sequencer #(
    parameter int BLK_PER_HALF = 16,
    parameter int BUF_AW       = 4,
    parameter int ROM_AW       = 6,
    parameter int ROM1_BASE    = 0,
    parameter int ROM2_BASE    = 8,
    parameter int ROM_STEP     = 2,
    parameter int ROM_GAP      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              buf_wr_en,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic              buf_rd_en,
    output logic [BUF_AW-1:0] buf_rd_addr,
    output logic              bf_valid,
    output logic [ROM_AW-1:0] rom1_addr,
    output logic [ROM_AW-1:0] rom2_addr,
    output logic              frame_done,
    output logic              busy
`ifdef STAGE_SEQ_FRMCNT_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAIR = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [BUF_AW-1:0] cnt;
    logic              cnt_last;
    logic              fill_acc;
    logic              pair_acc;
    logic [ROM_AW-1:0] rom_inc;

    assign cnt_last = (cnt == BUF_AW'(BLK_PER_HALF - 1));
    assign rom_inc  = cnt_last ? ROM_AW'(ROM_STEP + ROM_GAP) : ROM_AW'(ROM_STEP);

    // Next-state decode plus the combinational handshake and buffer strobes
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        buf_wr_en   = 1'b0;
        buf_wr_addr = '0;
        buf_rd_en   = 1'b0;
        buf_rd_addr = '0;
        busy        = 1'b0;
        fill_acc    = 1'b0;
        pair_acc    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    fill_acc    = 1'b1;
                    buf_wr_en   = 1'b1;
                    buf_wr_addr = cnt;
                    if (cnt_last) begin
                        state_next = PAIR;
                    end
                end
            end
            PAIR: begin
                busy     = 1'b1;
                in_ready = out_ready;
                if (in_valid && out_ready) begin
                    pair_acc    = 1'b1;
                    buf_rd_en   = 1'b1;
                    buf_rd_addr = cnt;
                    if (cnt_last) begin
                        state_next = enable ? FILL : IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; enable only matters at frame boundaries via the decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Block counter within the half-frame; the power-of-two size makes it wrap to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (fill_acc || pair_acc) begin
            cnt <= cnt + BUF_AW'(1);
        end
    end

    // Butterfly valid and frame pulse, one cycle after the paired accept
    always_ff @(posedge clk) begin
        if (rst) begin
            bf_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bf_valid   <= pair_acc;
            frame_done <= pair_acc && cnt_last;
        end
    end

    // Twiddle ROM addresses; they accumulate across frames and are reloaded only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rom1_addr <= ROM_AW'(ROM1_BASE);
            rom2_addr <= ROM_AW'(ROM2_BASE);
        end else if (pair_acc) begin
            rom1_addr <= rom1_addr + rom_inc;
            rom2_addr <= rom2_addr + rom_inc;
        end
    end

`ifdef STAGE_SEQ_FRMCNT_EN
    // Wrapping count of completed frames
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Saturating count of PAIR cycles where data waited on downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == PAIR) && in_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bfly_stage_sequencer.sv
// tb_bfly_stage_sequencer: self-checking bench for bfly_stage_sequencer.
// A frame-position reference model runs alongside the DUT. Scenario tasks add
// directed checks at the interesting points of each scenario.
// Define STAGE_SEQ_FRMCNT_EN to also exercise frame_cnt and stall_cnt.
module tb_bfly_stage_sequencer;

    localparam int HALF   = 16;
    localparam int BUF_AW = 4;
    localparam int ROM_AW = 6;
    localparam int R1     = 0;
    localparam int R2     = 8;
    localparam int STEP   = 2;
    localparam int GAP    = 8;
    localparam int ROM_MOD = 1 << ROM_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              out_ready = 1'b0;
    logic              buf_wr_en;
    logic [BUF_AW-1:0] buf_wr_addr;
    logic              buf_rd_en;
    logic [BUF_AW-1:0] buf_rd_addr;
    logic              bf_valid;
    logic [ROM_AW-1:0] rom1_addr;
    logic [ROM_AW-1:0] rom2_addr;
    logic              frame_done;
    logic              busy;
`ifdef STAGE_SEQ_FRMCNT_EN
    logic [15:0]       frame_cnt;
    logic [15:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Reference model: position of the next block in the 2*HALF-block frame
    bit m_run    = 1'b0;
    int m_k      = 0;
    int m_paired = 0;
    int m_frames = 0;
    bit m_bf     = 1'b0;
    bit m_fd     = 1'b0;
    int m_fcnt   = 0;
    int m_stall  = 0;

    bit                e_rdy;
    bit                e_wr;
    bit                e_rd;
    logic [ROM_AW-1:0] e_rom1;
    logic [ROM_AW-1:0] e_rom2;

    bfly_stage_sequencer #(
        .BLK_PER_HALF(HALF),
        .BUF_AW(BUF_AW),
        .ROM_AW(ROM_AW),
        .ROM1_BASE(R1),
        .ROM2_BASE(R2),
        .ROM_STEP(STEP),
        .ROM_GAP(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_ready(out_ready),
        .buf_wr_en(buf_wr_en),
        .buf_wr_addr(buf_wr_addr),
        .buf_rd_en(buf_rd_en),
        .buf_rd_addr(buf_rd_addr),
        .bf_valid(bf_valid),
        .rom1_addr(rom1_addr),
        .rom2_addr(rom2_addr),
        .frame_done(frame_done),
        .busy(busy)
`ifdef STAGE_SEQ_FRMCNT_EN
        ,
        .frame_cnt(frame_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance the reference model on every active edge
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_run = 1'b0; m_k = 0; m_paired = 0; m_frames = 0;
            m_bf = 1'b0; m_fd = 1'b0; m_fcnt = 0; m_stall = 0;
        end else begin
            acc = m_run && in_valid && (m_k < HALF || out_ready);
            if (m_fd) m_fcnt = (m_fcnt + 1) % 65536;
            if (m_run && m_k >= HALF && in_valid && !out_ready && m_stall < 65535)
                m_stall = m_stall + 1;
            m_bf = acc && (m_k >= HALF);
            m_fd = acc && (m_k == 2 * HALF - 1);
            if (acc) begin
                if (m_k >= HALF) m_paired = m_paired + 1;
                if (m_k == 2 * HALF - 1) begin
                    m_frames = m_frames + 1;
                    m_k = 0;
                    m_run = enable;
                end else begin
                    m_k = m_k + 1;
                end
            end else if (!m_run) begin
                m_run = enable;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        if (mon_on) begin
            e_rdy  = m_run && (m_k < HALF || out_ready);
            e_wr   = e_rdy && in_valid && (m_k < HALF);
            e_rd   = e_rdy && in_valid && (m_k >= HALF);
            e_rom1 = ROM_AW'((R1 + STEP * m_paired + GAP * m_frames) % ROM_MOD);
            e_rom2 = ROM_AW'((R2 + STEP * m_paired + GAP * m_frames) % ROM_MOD);
            checks = checks + 8;
            if (in_ready !== e_rdy) begin
                errors++; $display("[TB] FAIL mon_in_ready t=%0t got %b exp %b", $time, in_ready, e_rdy);
            end
            if (buf_wr_en !== e_wr) begin
                errors++; $display("[TB] FAIL mon_buf_wr_en t=%0t got %b exp %b", $time, buf_wr_en, e_wr);
            end
            if (buf_rd_en !== e_rd) begin
                errors++; $display("[TB] FAIL mon_buf_rd_en t=%0t got %b exp %b", $time, buf_rd_en, e_rd);
            end
            if (bf_valid !== m_bf) begin
                errors++; $display("[TB] FAIL mon_bf_valid t=%0t got %b exp %b", $time, bf_valid, m_bf);
            end
            if (frame_done !== m_fd) begin
                errors++; $display("[TB] FAIL mon_frame_done t=%0t got %b exp %b", $time, frame_done, m_fd);
            end
            if (busy !== m_run) begin
                errors++; $display("[TB] FAIL mon_busy t=%0t got %b exp %b", $time, busy, m_run);
            end
            if (rom1_addr !== e_rom1) begin
                errors++; $display("[TB] FAIL mon_rom1 t=%0t got %0d exp %0d", $time, rom1_addr, e_rom1);
            end
            if (rom2_addr !== e_rom2) begin
                errors++; $display("[TB] FAIL mon_rom2 t=%0t got %0d exp %0d", $time, rom2_addr, e_rom2);
            end
            if (e_wr) begin
                checks++;
                if (buf_wr_addr !== BUF_AW'(m_k)) begin
                    errors++; $display("[TB] FAIL mon_wr_addr t=%0t got %0d exp %0d", $time, buf_wr_addr, m_k);
                end
            end
            if (e_rd) begin
                checks++;
                if (buf_rd_addr !== BUF_AW'(m_k - HALF)) begin
                    errors++; $display("[TB] FAIL mon_rd_addr t=%0t got %0d exp %0d", $time, buf_rd_addr, m_k - HALF);
                end
            end
`ifdef STAGE_SEQ_FRMCNT_EN
            checks = checks + 2;
            if (frame_cnt !== 16'(m_fcnt)) begin
                errors++; $display("[TB] FAIL mon_frame_cnt t=%0t got %0d exp %0d", $time, frame_cnt, m_fcnt);
            end
            if (stall_cnt !== 16'(m_stall)) begin
                errors++; $display("[TB] FAIL mon_stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, m_stall);
            end
`endif
        end
    end

    // Move to one time unit after the next active edge
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        advance();
        rst = 1'b0;
    endtask

    // Hold in_valid/out_ready high for n cycles
    task automatic feed(input int n);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        advance();
        advance();
        rst = 1'b0;
        #1;
        checks = checks + 10;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_ready got %b exp 0", in_ready); end
        if (buf_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr_en got %b exp 0", buf_wr_en); end
        if (buf_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_rd_en got %b exp 0", buf_rd_en); end
        if (bf_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_bf_valid got %b exp 0", bf_valid); end
        if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_frame_done got %b exp 0", frame_done); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy); end
        if (buf_wr_addr !== 4'd0) begin errors++; $display("[TB] FAIL rst_wr_addr got %0d exp 0", buf_wr_addr); end
        if (buf_rd_addr !== 4'd0) begin errors++; $display("[TB] FAIL rst_rd_addr got %0d exp 0", buf_rd_addr); end
        if (rom1_addr !== 6'd0) begin errors++; $display("[TB] FAIL rst_rom1 got %0d exp 0", rom1_addr); end
        if (rom2_addr !== 6'd8) begin errors++; $display("[TB] FAIL rst_rom2 got %0d exp 8", rom2_addr); end
        mon_on = 1'b1;
        #4;
    endtask

    task automatic test_back_to_back();
        int b;
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        advance();
        for (int i = 0; i < 2 * 2 * HALF; i++) begin
            #1;
            b = i % (2 * HALF);
            checks++;
            if (b < HALF) begin
                if (buf_wr_en !== 1'b1 || buf_wr_addr !== BUF_AW'(b)) begin
                    errors++; $display("[TB] FAIL b2b_wr cyc=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, buf_wr_en, buf_wr_addr, b);
                end
            end else begin
                if (buf_rd_en !== 1'b1 || buf_rd_addr !== BUF_AW'(b - HALF)) begin
                    errors++; $display("[TB] FAIL b2b_rd cyc=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, buf_rd_en, buf_rd_addr, b - HALF);
                end
            end
            if (i == 16 || i == 31) begin
                checks++;
                if (rom1_addr !== ROM_AW'(2 * (i - 16)) || rom2_addr !== ROM_AW'(8 + 2 * (i - 16))) begin
                    errors++; $display("[TB] FAIL b2b_rom cyc=%0d got %0d/%0d exp %0d/%0d", i, rom1_addr, rom2_addr, 2 * (i - 16), 8 + 2 * (i - 16));
                end
            end
            if (i == 32) begin
                checks++;
                if (frame_done !== 1'b1 || bf_valid !== 1'b1 || rom1_addr !== 6'd40 || rom2_addr !== 6'd48) begin
                    errors++; $display("[TB] FAIL b2b_frame1_end got fd=%b bv=%b rom=%0d/%0d exp fd=1 bv=1 rom=40/48", frame_done, bf_valid, rom1_addr, rom2_addr);
                end
            end
            advance();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (frame_done !== 1'b1 || rom1_addr !== 6'd16 || rom2_addr !== 6'd24) begin
            errors++; $display("[TB] FAIL b2b_frame2_end got fd=%b rom=%0d/%0d exp fd=1 rom=16/24", frame_done, rom1_addr, rom2_addr);
        end
        advance();
    endtask

    task automatic test_stall();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        advance();
        feed(HALF + 4);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || buf_rd_en !== 1'b0 || rom1_addr !== 6'd8 || rom2_addr !== 6'd16) begin
                errors++; $display("[TB] FAIL stall_hold s=%0d got rdy=%b rd=%b rom=%0d/%0d exp rdy=0 rd=0 rom=8/16", s, in_ready, buf_rd_en, rom1_addr, rom2_addr);
            end
            checks++;
            if (bf_valid !== (s == 0)) begin
                errors++; $display("[TB] FAIL stall_bf_valid s=%0d got %b exp %b", s, bf_valid, s == 0);
            end
            advance();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (buf_rd_en !== 1'b1 || buf_rd_addr !== 4'd4 || rom1_addr !== 6'd8) begin
            errors++; $display("[TB] FAIL stall_resume got rd=%b addr=%0d rom1=%0d exp rd=1 addr=4 rom1=8", buf_rd_en, buf_rd_addr, rom1_addr);
        end
        feed(HALF - 4);
        in_valid = 1'b0;
        advance();
    endtask

    task automatic test_enable_drop();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        advance();
        feed(HALF + 5);
        enable = 1'b0;
        feed(HALF - 5);
        #1;
        checks++;
        if (frame_done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL endrop_end got fd=%b rdy=%b busy=%b exp fd=1 rdy=0 busy=0", frame_done, in_ready, busy);
        end
        for (int i = 0; i < 3; i++) begin
            advance();
            #1;
            checks++;
            if (in_ready !== 1'b0 || buf_wr_en !== 1'b0) begin
                errors++; $display("[TB] FAIL endrop_idle i=%0d got rdy=%b wr=%b exp 0/0", i, in_ready, buf_wr_en);
            end
        end
        enable = 1'b1;
        advance();
        #1;
        checks++;
        if (buf_wr_en !== 1'b1 || buf_wr_addr !== 4'd0 || rom1_addr !== 6'd40 || rom2_addr !== 6'd48) begin
            errors++; $display("[TB] FAIL endrop_restart got wr=%b addr=%0d rom=%0d/%0d exp wr=1 addr=0 rom=40/48", buf_wr_en, buf_wr_addr, rom1_addr, rom2_addr);
        end
        in_valid = 1'b0;
        advance();
    endtask

    task automatic test_reset_mid_fill();
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        advance();
        feed(2 * HALF + 10);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || buf_wr_en !== 1'b0 || bf_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_outputs got rdy=%b wr=%b bv=%b fd=%b busy=%b exp all 0", in_ready, buf_wr_en, bf_valid, frame_done, busy);
        end
        checks++;
        if (rom1_addr !== 6'd0 || rom2_addr !== 6'd8) begin
            errors++; $display("[TB] FAIL midrst_rom got %0d/%0d exp 0/8", rom1_addr, rom2_addr);
        end
        advance();
        #1;
        checks++;
        if (buf_wr_en !== 1'b1 || buf_wr_addr !== 4'd0) begin
            errors++; $display("[TB] FAIL midrst_restart got wr=%b addr=%0d exp wr=1 addr=0", buf_wr_en, buf_wr_addr);
        end
        in_valid = 1'b0;
        advance();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 399) == 0);
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            advance();
        end
        rst = 1'b0; in_valid = 1'b0;
        advance();
    endtask

`ifdef STAGE_SEQ_FRMCNT_EN
    task automatic test_frame_counters();
        int blk;
        int stalls;
        blk = 0;
        stalls = 0;
        apply_reset();
        enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        advance();
        while (blk < 3 * 2 * HALF) begin
            if ((blk % (2 * HALF)) >= HALF && $urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
                blk++;
            end
            advance();
        end
        in_valid = 1'b0;
        advance();
        #1;
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++; $display("[TB] FAIL frmcnt_frames got %0d exp 3", frame_cnt);
        end
        checks++;
        if (stall_cnt !== 16'(stalls)) begin
            errors++; $display("[TB] FAIL frmcnt_stalls got %0d exp %0d", stall_cnt, stalls);
        end
        advance();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_enable_drop();
        test_reset_mid_fill();
`ifdef STAGE_SEQ_FRMCNT_EN
        test_frame_counters();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
